// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
//
// Shared definitions for the UART transmit arbiter:
//   arb_state_e : sequencer states (IDLE, TAG, FETCH, ISSUE, SETTLE, WAIT)
//   TAG_NIBBLE  : upper nibble of the per-grant tag byte (0xA0 | grant_id)
//   id_width()  : width of a requester index, never less than one bit
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TAG,
    FETCH,
    ISSUE,
    SETTLE,
    WAIT
  } arb_state_e;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. Searches req upward starting at ptr+1,
// wrapping modulo NUM_REQ, and returns the first set index. ptr itself is the
// last candidate examined, so the previous owner has the lowest priority.
//
// Ports:
//   req   in  NUM_REQ : request vector
//   ptr   in  IDW     : index of the most recently served requester
//   found out 1       : at least one request is set
//   idx   out IDW     : winning index (0 when found is low)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  localparam logic [IDW:0] N_W = (IDW+1)'(NUM_REQ);

  // cand_idx[k] is the k-th index visited by the search; cand_hit[k] says
  // whether that requester is asking.
  logic [IDW-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      // ptr <= NUM_REQ-1 and gi+1 <= NUM_REQ, so one subtraction wraps it.
      assign sum           = {1'b0, ptr} + (IDW+1)'(gi + 1);
      assign cand_idx[gi]  = (sum >= N_W) ? IDW'(sum - N_W) : sum[IDW-1:0];
      assign cand_hit[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the nearest candidate overwrites the others.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        found = 1'b1;
        idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter/sequencer sharing one uart_tx byte transmitter among
// NUM_REQ requesters. A grant is held for a whole message (until req_last is
// accepted) or until MAX_BURST data bytes have been sent, whichever is first.
// Every byte walks FETCH -> ISSUE -> SETTLE -> WAIT, so one byte costs at
// least four cycles.
//
// Optional feature (macro UART_ARB_TAG_EN): when defined, every grant starts
// with a tag byte {4'hA, grant_id}; the tag does not count toward the burst.
// When undefined, the TAG state and tag_flag are compiled out.
//
// Ports:
//   clk          in  1          : clock
//   rst          in  1          : synchronous active-high reset
//   req_valid    in  NUM_REQ    : requester i has a byte
//   req_data     in  8*NUM_REQ  : byte of requester i at [8i+7:8i]
//   req_last     in  NUM_REQ    : offered byte ends the message
//   req_ready    out NUM_REQ    : one-hot accept (combinational)
//   tx_start     out 1          : one-cycle start pulse to uart_tx
//   tx_data      out 8          : byte to uart_tx
//   tx_busy      in  1          : uart_tx busy flag
//   grant_active out 1          : a requester owns the transmitter
//   grant_id     out clog2(N)   : owner index, valid with grant_active
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  localparam int IDW      = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [IDW-1:0]       grant_id
);

  localparam logic [7:0]     BURST_LIM  = 8'(MAX_BURST);
  localparam logic [IDW-1:0] PTR_RESET  = IDW'(NUM_REQ - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e     state_q,        state_d;
  logic [IDW-1:0] rr_ptr_q,       rr_ptr_d;
  logic [IDW-1:0] grant_id_q,     grant_id_d;
  logic           grant_active_q, grant_active_d;
  logic [7:0]     burst_cnt_q,    burst_cnt_d;
  logic [7:0]     hold_byte_q,    hold_byte_d;
  logic           hold_last_q,    hold_last_d;
  logic           tx_start_q,     tx_start_d;
  logic [7:0]     tx_data_q,      tx_data_d;
`ifdef UART_ARB_TAG_EN
  logic           tag_flag_q,     tag_flag_d;
`endif

  // ---------------------------------------------------------------------------
  // Owner's input lane
  // ---------------------------------------------------------------------------
  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;

  assign own_valid = req_valid[grant_id_q];
  assign own_last  = req_last[grant_id_q];
  assign own_data  = req_data[{grant_id_q, 3'b000} +: 8];

  // ---------------------------------------------------------------------------
  // Round-robin decision, only consumed in IDLE
  // ---------------------------------------------------------------------------
  logic           pick_found;
  logic [IDW-1:0] pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    burst_cnt_d    = burst_cnt_q;
    hold_byte_d    = hold_byte_q;
    hold_last_d    = hold_last_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
`ifdef UART_ARB_TAG_EN
    tag_flag_d     = tag_flag_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d     = pick_idx;
          grant_active_d = 1'b1;
          burst_cnt_d    = 8'd0;
`ifdef UART_ARB_TAG_EN
          state_d        = TAG;
`else
          state_d        = FETCH;
`endif
        end
      end

`ifdef UART_ARB_TAG_EN
      TAG: begin
        hold_byte_d = {TAG_NIBBLE, 4'(grant_id_q)};
        tag_flag_d  = 1'b1;
        state_d     = ISSUE;
      end
`endif

      FETCH: begin
        // A message is never abandoned: wait here for the owner's next byte.
        if (own_valid) begin
          hold_byte_d = own_data;
          hold_last_d = own_last;
          burst_cnt_d = burst_cnt_q + 8'd1;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = hold_byte_q;
          state_d    = SETTLE;
        end
      end

      // uart_tx raises busy one cycle after it sees start; skip that cycle.
      SETTLE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
          if (tag_flag_q) begin
            tag_flag_d = 1'b0;
            state_d    = FETCH;
          end else
`endif
          if (hold_last_q || (burst_cnt_q == BURST_LIM)) begin
            rr_ptr_d       = grant_id_q;
            grant_active_d = 1'b0;
            state_d        = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Ready is combinational so the owner's byte can be taken in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    if (state_q == FETCH) begin
      req_ready[grant_id_q] = own_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= PTR_RESET;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      burst_cnt_q    <= 8'd0;
      hold_byte_q    <= 8'h00;
      hold_last_q    <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
`ifdef UART_ARB_TAG_EN
      tag_flag_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      burst_cnt_q    <= burst_cnt_d;
      hold_byte_q    <= hold_byte_d;
      hold_last_q    <= hold_last_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
`ifdef UART_ARB_TAG_EN
      tag_flag_q     <= tag_flag_d;
`endif
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` byte transmitter among `NUM_REQ` requesters. Each requester hands over bytes through a valid/ready handshake. A grant is held across a multi-byte message until the requester flags the last byte, or until a burst limit is reached. The arbiter drives `uart_tx`'s `start`/`data` inputs, observes its `busy` output, and sits directly upstream of `uart_tx` in the debug/console path.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `MAX_BURST`, 16: maximum data bytes per grant, 1..255.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NUM_REQ: requester i has a byte available.
- `req_data` in 8*NUM_REQ: byte for requester i at bits `[8i+7:8i]`.
- `req_last` in NUM_REQ: the byte offered by requester i ends its message.
- `req_ready` out NUM_REQ: one-hot; byte accepted when `req_valid[i] && req_ready[i]`.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data` out 8: byte to `uart_tx`, stable while `tx_start` is high.
- `tx_busy` in 1: `uart_tx` busy flag.
- `grant_active` out 1: a requester currently owns the transmitter.
- `grant_id` out `$clog2(NUM_REQ)`: index of the owner; valid only when `grant_active` is high.

## Operation
States: IDLE, TAG, FETCH, ISSUE, SETTLE, WAIT.

- **IDLE:** if any `req_valid` is high, pick the first set index searching upward from `rr_ptr+1`, wrapping modulo NUM_REQ. Register it as `grant_id`, set `grant_active`, clear `burst_cnt`, then go to TAG when `UART_ARB_TAG_EN` is defined, else FETCH.
- **TAG:** load `hold_byte = {4'hA, grant_id[3:0]}` and set `tag_flag`, then go to ISSUE.
- **FETCH:** `req_ready[grant_id] = req_valid[grant_id]`; all other `req_ready` bits are 0.
  - On handshake, capture `req_data` and `req_last` into `hold_byte` and `hold_last`, increment `burst_cnt`, then go to ISSUE.
  - With no valid, stay in FETCH. A message is never abandoned mid-way.
- **ISSUE:** when `tx_busy==0`, drive `tx_start=1` with `tx_data=hold_byte` for exactly one cycle, then go to SETTLE. While `tx_busy==1`, stay with `tx_start=0`.
- **SETTLE:** one cycle; `tx_busy` is ignored. Go to WAIT.
- **WAIT:** stay while `tx_busy==1`. When `tx_busy==0`:
  - if `tag_flag`: clear it, go to FETCH;
  - else if `hold_last` or `burst_cnt==MAX_BURST`: release. Set `rr_ptr=grant_id`, clear `grant_active`, go to IDLE;
  - else go to FETCH.
- The tag byte does not count toward `burst_cnt`.
- `req_ready` is combinational from registered state and `req_valid`. All other outputs are registered.
- Only one requester ever sees `req_ready` high.

## Timing
- Reset values:
  - outputs: `tx_start=0`, `tx_data=8'h00`, `req_ready=0`, `grant_active=0`, `grant_id=0`;
  - internal: state IDLE, `rr_ptr=NUM_REQ-1` so requester 0 wins first, `burst_cnt=0`, `tag_flag=0`.
- IDLE to FETCH takes 1 cycle. The first `req_ready` appears in the cycle after the grant decision.
- Minimum cost per byte is 4 cycles (FETCH, ISSUE, SETTLE, WAIT) when `tx_busy` stays low. Back-to-back bytes from one requester are accepted at most every 4 cycles.
- Release to the next grant takes 1 cycle: WAIT to IDLE, then IDLE decides in that cycle.
- Simultaneous requests: resolved strictly by rotation; the releasing requester has the lowest priority at the next decision.
- A grant also ends at `MAX_BURST` even without `req_last`; the requester re-arbitrates for the remainder.
- `rst` asserted in any state: the next cycle is IDLE with reset values. A pending `tx_start` is dropped, and `uart_tx` is reset externally by the same `rst`.
- `req_last` is sampled only on handshake.

## Configuration
- **`UART_ARB_TAG_EN` defined:** each grant begins with one tag byte `0xA0 | grant_id` before the requester's first data byte.
- **Undefined:** the TAG state and `tag_flag` are compiled out; only requester bytes reach `tx_data`.

## Structure
- **Package `uart_arb_pkg`:** state enum (IDLE, TAG, FETCH, ISSUE, SETTLE, WAIT), `TAG_NIBBLE = 4'hA`, and an id-width function wrapping `$clog2`.
- **Sub-module `rr_pick`:** combinational round-robin picker with inputs `req[NUM_REQ]` and `ptr`, outputs `found` and `idx`. It is instantiated once in IDLE logic.

## Test plan
- **Single requester:** req0 sends 3 bytes `0x41, 0x42, 0x43`, last on `0x43`, with `tx_busy` tied 0. Required: 3 `tx_start` pulses 4 cycles apart with matching `tx_data`, then `grant_active` falls.
- **All four requesting one-byte messages:** grants occur in order 0, 1, 2, 3. A re-request by 0 after its release is served after 3.
- **Burst limit:** `MAX_BURST=2`; req1 streams 5 bytes with last on the 5th while req2 waits. Required order on `tx_data`: req1 ×2, req2, req1 ×2, req2-free gap, req1 ×1.
- **Busy stretching:** the model holds `tx_busy=1` for 10 cycles after each start. Required: no `tx_start` while busy and exactly one pulse per byte; a start pulse seen during busy is an error.
- **Reset mid-message:** `rst` asserted in WAIT of byte 2 of 4. Required: the next cycle shows `grant_active=0` and `req_ready=0`; after release, requester 0 wins first.
- **`UART_ARB_TAG_EN`:** req3 sends `0x55`. Required: `tx_data` sequence `0xA3`, then `0x55`; `burst_cnt` reaches only 1.
